// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Shares one RF write port between the pipeline write-back path, a small FIFO
// of multi-cycle unit results, and a debug/loader port. The pipeline wins by
// default; a starvation guard periodically steals one pipeline cycle so that
// buffered results drain.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_we_in,
    input  logic [3:0]             wb_addr_in,
    input  logic [31:0]            wb_data_in,
    input  logic                   aux_valid,
    output logic                   aux_ready,
    input  logic [3:0]             aux_addr,
    input  logic [31:0]            aux_data,
    input  logic                   dbg_req,
    input  logic [3:0]             dbg_addr,
    input  logic [31:0]            dbg_data,
    output logic                   dbg_ack,
    output logic                   rf_we,
    output logic [3:0]             rf_addr,
    output logic [31:0]            rf_data,
    output logic                   pipe_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_AUX,
        GRANT_DBG
    } grant_e;

    logic [3:0]    mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic [3:0]    last_addr_q;
    logic [31:0]   last_data_q;

    grant_e        grant;
    logic          fifo_empty;
    logic          fifo_ready;
    logic          push;
    logic          pop;
    logic [3:0]    sel_addr;
    logic [31:0]   sel_data;

    // Readiness deliberately ignores a same-cycle pop so aux_ready has no
    // combinational path from the grant logic.
    assign fifo_empty = (count_q == '0);
    assign fifo_ready = (count_q != FULL_COUNT);
    assign push       = aux_valid && fifo_ready;

    // Fixed-priority grant: forced drain slot, pipeline, buffered result, debug.
    always_comb begin
        grant = GRANT_NONE;
        if (stall_q && !fifo_empty) begin
            grant = GRANT_AUX;
        end else if (wb_we_in && !stall_q) begin
            grant = GRANT_WB;
        end else if (!fifo_empty) begin
            grant = GRANT_AUX;
        end else if (dbg_req) begin
            grant = GRANT_DBG;
        end
    end

    assign pop = (grant == GRANT_AUX);

    // Steer the granted source onto the write port, otherwise hold the last write.
    always_comb begin
        sel_addr = last_addr_q;
        sel_data = last_data_q;
        case (grant)
            GRANT_WB: begin
                sel_addr = wb_addr_in;
                sel_data = wb_data_in;
            end
            GRANT_AUX: begin
                sel_addr = mem_addr_q[rd_ptr_q];
                sel_data = mem_data_q[rd_ptr_q];
            end
            GRANT_DBG: begin
                sel_addr = dbg_addr;
                sel_data = dbg_data;
            end
            default: begin
                sel_addr = last_addr_q;
                sel_data = last_data_q;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, even if sources are active.
    assign rf_we      = reset && (grant != GRANT_NONE);
    assign rf_addr    = reset ? sel_addr : last_addr_q;
    assign rf_data    = reset ? sel_data : last_data_q;
    assign dbg_ack    = reset && (grant == GRANT_DBG);
    assign aux_ready  = reset && fifo_ready;
    assign pipe_stall = stall_q;
    assign fifo_count = count_q;

    // Next-state for FIFO bookkeeping, starvation counter and the stall slot.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == STARVE_MAX);
    end

    // Control state and the last-granted write, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            last_addr_q <= sel_addr;
            last_data_q <= sel_data;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= aux_addr;
            mem_data_q[wr_ptr_q] <= aux_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios followed by randomized
// traffic, all checked by a scoreboard fed from a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_we_in;
    logic [3:0]    wb_addr_in;
    logic [31:0]   wb_data_in;
    logic          aux_valid;
    logic          aux_ready;
    logic [3:0]    aux_addr;
    logic [31:0]   aux_data;
    logic          dbg_req;
    logic [3:0]    dbg_addr;
    logic [31:0]   dbg_data;
    logic          dbg_ack;
    logic          rf_we;
    logic [3:0]    rf_addr;
    logic [31:0]   rf_data;
    logic          pipe_stall;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_we_in(wb_we_in),
        .wb_addr_in(wb_addr_in),
        .wb_data_in(wb_data_in),
        .aux_valid(aux_valid),
        .aux_ready(aux_ready),
        .aux_addr(aux_addr),
        .aux_data(aux_data),
        .dbg_req(dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .dbg_ack(dbg_ack),
        .rf_we(rf_we),
        .rf_addr(rf_addr),
        .rf_data(rf_data),
        .pipe_stall(pipe_stall),
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic          we;
        logic [3:0]    addr;
        logic [31:0]   data;
        logic          ack;
        logic          stall;
        logic          ready;
        logic [CW-1:0] count;
    } expect_t;

    entry_t      modelFifo[$];
    expect_t     expQ[$];
    int          modelStarve = 0;
    bit          modelStall = 0;
    logic [3:0]  modelLastAddr = '0;
    logic [31:0] modelLastData = '0;
    bit          lastAccepted = 0;
    bit          lastAcked = 0;
    bit          lastStall = 0;
    int          checkCount = 0;
    int          passCount = 0;

    // Single comparison point shared by the monitor and directed checks.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: evaluates one cycle from the current inputs, queues the
    // expected outputs and advances the model state.
    task automatic applyStimulus();
        expect_t e;
        int      sz;
        bit      popped;
        entry_t  head;
        entry_t  incoming;
        e.we = 0; e.addr = '0; e.data = '0; e.ack = 0; e.stall = 0; e.ready = 0; e.count = '0;
        if (!reset) begin
            modelFifo.delete();
            modelStarve   = 0;
            modelStall    = 0;
            modelLastAddr = '0;
            modelLastData = '0;
            lastAccepted  = 0;
            lastAcked     = 0;
            lastStall     = 0;
        end else begin
            sz      = modelFifo.size();
            popped  = 0;
            e.ready = (sz < DEPTH);
            e.stall = modelStall;
            e.count = CW'(sz);
            if (modelStall && sz > 0) begin
                head = modelFifo.pop_front();
                popped = 1;
                e.we = 1; modelLastAddr = head.addr; modelLastData = head.data;
            end else if (wb_we_in && !modelStall) begin
                e.we = 1; modelLastAddr = wb_addr_in; modelLastData = wb_data_in;
            end else if (sz > 0) begin
                head = modelFifo.pop_front();
                popped = 1;
                e.we = 1; modelLastAddr = head.addr; modelLastData = head.data;
            end else if (dbg_req) begin
                e.we = 1; e.ack = 1; modelLastAddr = dbg_addr; modelLastData = dbg_data;
            end
            e.addr = modelLastAddr;
            e.data = modelLastData;
            lastAccepted = aux_valid && e.ready;
            if (lastAccepted) begin
                incoming.addr = aux_addr;
                incoming.data = aux_data;
                modelFifo.push_back(incoming);
            end
            if (sz == 0 || popped) modelStarve = 0;
            else if (modelStarve < STARVE_LIMIT) modelStarve++;
            modelStall = (modelStarve == STARVE_LIMIT);
            lastAcked  = e.ack;
            lastStall  = e.stall;
        end
        expQ.push_back(e);
    endtask

    task automatic setInputs(input logic wbWe, input logic [3:0] wbA, input logic [31:0] wbD,
                             input logic auxV, input logic [3:0] auxA, input logic [31:0] auxD,
                             input logic dbgR, input logic [3:0] dbgA, input logic [31:0] dbgD);
        wb_we_in = wbWe; wb_addr_in = wbA; wb_data_in = wbD;
        aux_valid = auxV; aux_addr = auxA; aux_data = auxD;
        dbg_req = dbgR; dbg_addr = dbgA; dbg_data = dbgD;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus();
            tick();
        end
    endtask

    // Monitor: every falling edge, pop the expected cycle and compare all outputs.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("rf_we",      32'(rf_we),      32'(e.we));
                checkOutput("rf_addr",    32'(rf_addr),    32'(e.addr));
                checkOutput("rf_data",    rf_data,         e.data);
                checkOutput("dbg_ack",    32'(dbg_ack),    32'(e.ack));
                checkOutput("pipe_stall", 32'(pipe_stall), 32'(e.stall));
                checkOutput("aux_ready",  32'(aux_ready),  32'(e.ready));
                checkOutput("fifo_count", 32'(fifo_count), 32'(e.count));
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic obeying the handshakes.
    initial begin
        reset = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(); tick();
        applyStimulus(); #2;
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_aux_ready", 32'(aux_ready), 32'd0);
        checkOutput("reset_rf_addr", 32'(rf_addr), 32'd0);
        tick();
        reset = 1'b1;

        // Pipeline only
        setInputs(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("wb_we", 32'(rf_we), 32'd1);
        checkOutput("wb_addr", 32'(rf_addr), 32'd5);
        checkOutput("wb_data", rf_data, 32'hDEADBEEF);
        tick();
        setInputs(0, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("wb_idle_we", 32'(rf_we), 32'd0);
        tick();

        // Aux result during an idle pipeline
        setInputs(0, 0, 0, 1, 4'd3, 32'h12, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("aux_push_no_write", 32'(rf_we), 32'd0);
        tick();
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("aux_we", 32'(rf_we), 32'd1);
        checkOutput("aux_addr", 32'(rf_addr), 32'd3);
        checkOutput("aux_data", rf_data, 32'h12);
        tick();
        applyStimulus(); #2;
        checkOutput("aux_drained_count", 32'(fifo_count), 32'd0);
        tick();

        // Starvation: WB busy on addr 2 while addr 7 waits in the FIFO
        setInputs(1, 4'd2, 32'h2222, 1, 4'd7, 32'h7777, 0, 0, 0);
        applyStimulus(); tick();
        for (int i = 0; i < 3; i++) begin
            setInputs(1, 4'd2, 32'h2222, 0, 0, 0, 0, 0, 0);
            applyStimulus(); #2;
            checkOutput("starve_wb_addr", 32'(rf_addr), 32'd2);
            checkOutput("starve_no_stall", 32'(pipe_stall), 32'd0);
            tick();
        end
        applyStimulus(); #2;
        checkOutput("stall_slot", 32'(pipe_stall), 32'd1);
        checkOutput("stall_addr", 32'(rf_addr), 32'd7);
        tick();
        applyStimulus(); #2;
        checkOutput("stall_cleared", 32'(pipe_stall), 32'd0);
        checkOutput("wb_resumed_addr", 32'(rf_addr), 32'd2);
        tick();
        idleCycles(2);

        // Full FIFO with WB busy, then drain in order with pointer wrap
        for (int i = 1; i <= 4; i++) begin
            setInputs(1, 4'd8, 32'h8888, 1, 4'(i), 32'(i * 16'h1111), 0, 0, 0);
            applyStimulus(); tick();
        end
        setInputs(1, 4'd8, 32'h8888, 1, 4'd5, 32'h5555, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("full_ready", 32'(aux_ready), 32'd0);
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        checkOutput("full_stall_addr", 32'(rf_addr), 32'd1);
        tick();
        applyStimulus(); #2;
        checkOutput("after_pop_ready", 32'(aux_ready), 32'd1);
        tick();
        for (int i = 2; i <= 5; i++) begin
            setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(); #2;
            checkOutput("drain_order", 32'(rf_addr), 32'(i));
            tick();
        end
        idleCycles(1);

        // Debug waits behind a buffered result
        setInputs(0, 0, 0, 1, 4'd4, 32'h44, 0, 0, 0);
        applyStimulus(); tick();
        setInputs(0, 0, 0, 0, 0, 0, 1, 4'd9, 32'hA5);
        applyStimulus(); #2;
        checkOutput("dbg_wait_ack", 32'(dbg_ack), 32'd0);
        checkOutput("dbg_wait_addr", 32'(rf_addr), 32'd4);
        tick();
        applyStimulus(); #2;
        checkOutput("dbg_ack", 32'(dbg_ack), 32'd1);
        checkOutput("dbg_addr", 32'(rf_addr), 32'd9);
        checkOutput("dbg_data", rf_data, 32'hA5);
        tick();
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("dbg_ack_pulse", 32'(dbg_ack), 32'd0);
        checkOutput("hold_addr", 32'(rf_addr), 32'd9);
        tick();

        // Reset mid-fill
        setInputs(1, 4'd1, 32'h1, 1, 4'd10, 32'hAA, 0, 0, 0);
        applyStimulus(); tick();
        setInputs(1, 4'd1, 32'h1, 1, 4'd11, 32'hBB, 0, 0, 0);
        applyStimulus(); tick();
        reset = 1'b0;
        setInputs(1, 4'd1, 32'h1, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("midreset_count", 32'(fifo_count), 32'd0);
        checkOutput("midreset_we", 32'(rf_we), 32'd0);
        checkOutput("midreset_ready", 32'(aux_ready), 32'd0);
        tick();
        reset = 1'b1;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(); #2;
        checkOutput("postreset_ready", 32'(aux_ready), 32'd1);
        checkOutput("postreset_we", 32'(rf_we), 32'd0);
        tick();
        idleCycles(2);

        // Randomized traffic; sources hold requests exactly as the handshakes require
        for (int i = 0; i < 600; i++) begin
            if (!(lastStall && wb_we_in)) begin
                wb_we_in   = ($urandom_range(0, 99) < 60);
                wb_addr_in = 4'($urandom);
                wb_data_in = $urandom;
            end
            if (!(aux_valid && !lastAccepted)) begin
                aux_valid = ($urandom_range(0, 99) < 45);
                aux_addr  = 4'($urandom);
                aux_data  = $urandom;
            end
            if (!(dbg_req && !lastAcked)) begin
                dbg_req  = ($urandom_range(0, 99) < 10);
                dbg_addr = 4'($urandom);
                dbg_data = $urandom;
            end
            applyStimulus();
            tick();
        end
        idleCycles(10);

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
